// File: rtl/imp_axi_pkg.sv
// Shared AXI4-lite read-path types and constants for the IMP slave.
// Provides response codes, the R-beat bundle and the response queue depth.
package imp_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int IMP_RQ_DEPTH = 3;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_beat_t;

endpackage

// File: rtl/slv_imp_r_ch_if.sv
// AXI4-lite AR + R channel bundle for the IMP read slave.
// master: drives arvalid/araddr/arprot/rready; slave: drives arready/rvalid/rdata/rresp.
interface slv_imp_r_ch_if;

    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;

    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;

    modport master (
        output s_axi_arvalid,
        output s_axi_araddr,
        output s_axi_arprot,
        output s_axi_rready,
        input  s_axi_arready,
        input  s_axi_rvalid,
        input  s_axi_rdata,
        input  s_axi_rresp
    );

    modport slave (
        input  s_axi_arvalid,
        input  s_axi_araddr,
        input  s_axi_arprot,
        input  s_axi_rready,
        output s_axi_arready,
        output s_axi_rvalid,
        output s_axi_rdata,
        output s_axi_rresp
    );

endinterface

// File: rtl/imp_r_fifo.sv
// Synchronous FIFO of R beats (DEPTH entries, need not be a power of two).
// Ports: i_clk/i_rst, i_push/i_din, i_pop/o_dout (head), o_full, o_empty, o_count.
module imp_r_fifo
    import imp_axi_pkg::*;
#(
    parameter int DEPTH = IMP_RQ_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  r_beat_t       i_din,
    input  logic          i_pop,
    output r_beat_t       o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    r_beat_t       r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_nxt(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_nxt(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/slv_imp_r_ch.sv
// AXI4-lite read-only slave in front of a 1-cycle-latency SRAM read port.
// Ports: clk_IMP/rst_IMP, axi (AR+R slave), mem_rd_*, stat_clr/stat_rd_cnt/stat_err_cnt.
module slv_imp_r_ch
    import imp_axi_pkg::*;
#(
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk_IMP,
    input  logic              rst_IMP,
    slv_imp_r_ch_if.slave     axi,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    input  logic              stat_clr,
    output logic [31:0]       stat_rd_cnt,
    output logic [15:0]       stat_err_cnt
);

    localparam int CW = $clog2(IMP_RQ_DEPTH + 1);

    logic [31:0]   w_off;
    logic [31:0]   w_word;
    logic          w_inr;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic [2:0]    w_occ;
    r_beat_t       w_push_beat;
    r_beat_t       w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic          w_unused;

    logic          r_infl;
    logic          r_infl_inr;
    logic [31:0]   r_rd_cnt;
    logic [15:0]   r_err_cnt;

    // Byte address bits [1:0] never reach the word index.
    assign w_off  = {axi.s_axi_araddr[31:2], 2'b00} - BASE_ADDR;
    assign w_word = {2'b00, w_off[31:2]};
    assign w_inr  = ((w_word >> MEM_AW) == 32'd0);

    // Slots in use = queued beats + the read whose data lands this cycle.
    // Only registered state feeds arready; reset merely forces it low.
    assign w_occ = 3'(w_count) + 3'(r_infl);
    assign axi.s_axi_arready = !rst_IMP && (w_occ < 3'(IMP_RQ_DEPTH));

    assign w_ar_hs = axi.s_axi_arvalid && axi.s_axi_arready;

    assign mem_rd_en   = w_ar_hs && w_inr;
    assign mem_rd_addr = mem_rd_en ? w_word[MEM_AW-1:0] : '0;

    always_ff @(posedge clk_IMP) begin
        if (rst_IMP) begin
            r_infl     <= 1'b0;
            r_infl_inr <= 1'b0;
        end else begin
            r_infl     <= w_ar_hs;
            r_infl_inr <= w_ar_hs && w_inr;
        end
    end

    // Out-of-range reads still produce a beat so responses stay in order.
    assign w_push_beat.data = r_infl_inr ? mem_rd_data : 32'h0;
    assign w_push_beat.resp = r_infl_inr ? AXI_RESP_OKAY : AXI_RESP_SLVERR;

    imp_r_fifo #(
        .DEPTH (IMP_RQ_DEPTH)
    ) u_fifo (
        .i_clk   (clk_IMP),
        .i_rst   (rst_IMP),
        .i_push  (r_infl),
        .i_din   (w_push_beat),
        .i_pop   (w_r_hs),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign axi.s_axi_rvalid = !rst_IMP && !w_empty;
    assign axi.s_axi_rdata  = axi.s_axi_rvalid ? w_head.data : 32'h0;
    assign axi.s_axi_rresp  = axi.s_axi_rvalid ? w_head.resp : 2'b00;

    assign w_r_hs = axi.s_axi_rvalid && axi.s_axi_rready;

    always_ff @(posedge clk_IMP) begin
        if (rst_IMP || stat_clr) begin
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (w_r_hs) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_head.resp == AXI_RESP_SLVERR && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign stat_rd_cnt  = rst_IMP ? 32'h0 : r_rd_cnt;
    assign stat_err_cnt = rst_IMP ? 16'h0 : r_err_cnt;

    assign w_unused = ^{axi.s_axi_arprot, axi.s_axi_araddr[1:0], w_off[1:0], w_full};

endmodule

// File: tb/tb_slv_imp_r_ch.sv
// Testbench for slv_imp_r_ch: directed scenarios plus randomized traffic
// checked cycle by cycle against a queue-based model of the read channel.
module tb_slv_imp_r_ch;

    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk_IMP = 1'b0;
    logic          rst_IMP = 1'b1;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data = 32'h0;
    logic          stat_clr = 1'b0;
    logic [31:0]   stat_rd_cnt;
    logic [15:0]   stat_err_cnt;

    slv_imp_r_ch_if axi ();

    slv_imp_r_ch #(
        .MEM_AW    (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_IMP      (clk_IMP),
        .rst_IMP      (rst_IMP),
        .axi          (axi),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .stat_clr     (stat_clr),
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_err_cnt (stat_err_cnt)
    );

    always #5 clk_IMP = ~clk_IMP;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // SRAM model: one-cycle read latency, garbage when not enabled.
    logic [31:0] mem [1 << AW];

    always @(posedge clk_IMP) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        else           mem_rd_data <= $urandom;
    end

    // Reference model: every accepted read owes one beat, in order; a beat
    // becomes visible two cycles after its request; at most 3 are owed.
    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        int          c;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          cyc = 0;
    logic [31:0] m_rd = 0;
    logic [15:0] m_err = 0;
    logic [31:0] m_word;
    logic        m_inr, e_ar, e_rv, m_hs, m_rhs;

    always @(negedge clk_IMP) begin
        cyc++;
        if (rst_IMP) begin
            chk("rst_arready", 32'(axi.s_axi_arready), 0);
            chk("rst_rvalid", 32'(axi.s_axi_rvalid), 0);
            chk("rst_rdata", axi.s_axi_rdata, 0);
            chk("rst_rresp", 32'(axi.s_axi_rresp), 0);
            chk("rst_mem_en", 32'(mem_rd_en), 0);
            chk("rst_mem_addr", 32'(mem_rd_addr), 0);
            chk("rst_rd_cnt", stat_rd_cnt, 0);
            chk("rst_err_cnt", 32'(stat_err_cnt), 0);
            q.delete();
            m_rd  = 0;
            m_err = 0;
        end else begin
            e_ar = (q.size() < 3);
            e_rv = (q.size() > 0) && ((cyc - q[0].c) >= 2);
            chk("arready", 32'(axi.s_axi_arready), 32'(e_ar));
            chk("rvalid", 32'(axi.s_axi_rvalid), 32'(e_rv));
            if (e_rv) begin
                chk("rdata", axi.s_axi_rdata, q[0].d);
                chk("rresp", 32'(axi.s_axi_rresp), 32'(q[0].r));
            end
            chk("rd_cnt", stat_rd_cnt, m_rd);
            chk("err_cnt", 32'(stat_err_cnt), 32'(m_err));
            m_hs   = e_ar && axi.s_axi_arvalid;
            m_word = ((axi.s_axi_araddr & ~32'h3) - BASE) >> 2;
            m_inr  = (m_word < (32'd1 << AW));
            chk("mem_en", 32'(mem_rd_en), 32'(m_hs && m_inr));
            if (m_hs && m_inr) chk("mem_addr", 32'(mem_rd_addr), m_word);
            m_rhs = e_rv && axi.s_axi_rready;
            if (stat_clr) begin
                m_rd  = 0;
                m_err = 0;
            end
            if (m_rhs) begin
                e = q.pop_front();
                if (!stat_clr) begin
                    m_rd = m_rd + 1;
                    if (e.r == 2'b10 && m_err != 16'hFFFF) m_err = m_err + 1;
                end
            end
            if (m_hs) begin
                q.push_back('{m_inr ? mem[m_word[AW-1:0]] : 32'h0,
                              m_inr ? 2'b00 : 2'b10, cyc});
            end
        end
    end

    int stalls = 0;

    // Present one AR and hold it until accepted (bounded).
    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        axi.s_axi_arvalid = 1'b1;
        axi.s_axi_araddr  = a;
        axi.s_axi_arprot  = 3'($urandom);
        do begin
            @(negedge clk_IMP);
            n++;
        end while (!axi.s_axi_arready && n < 50);
        if (!axi.s_axi_arready) chk("ar_timeout", 32'(axi.s_axi_arready), 1);
        stalls += n - 1;
        @(posedge clk_IMP);
        #1;
        axi.s_axi_arvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_IMP);
            #1;
        end
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
    endtask

    logic [31:0] a;
    int          acc;
    bit          done;

    initial begin
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_araddr  = 32'h0;
        axi.s_axi_arprot  = 3'h0;
        axi.s_axi_rready  = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[4] = 32'hDEAD_BEEF;

        idle(3);
        rst_IMP = 1'b0;
        @(negedge clk_IMP);
        chk("post_rst_arready", 32'(axi.s_axi_arready), 1);
        idle(1);

        // single read
        axi.s_axi_rready = 1'b1;
        send_ar(32'h0000_0010);
        @(negedge clk_IMP);
        chk("single_early", 32'(axi.s_axi_rvalid), 0);
        idle(1);
        @(negedge clk_IMP);
        chk("single_rvalid", 32'(axi.s_axi_rvalid), 1);
        chk("single_rdata", axi.s_axi_rdata, 32'hDEAD_BEEF);
        chk("single_rresp", 32'(axi.s_axi_rresp), 0);
        idle(3);

        // streaming
        pulse_clr();
        stalls = 0;
        for (int i = 0; i < 32; i++) send_ar(32'(i * 4));
        chk("stream_stalls", 32'(stalls), 0);
        idle(4);
        chk("stream_cnt", stat_rd_cnt, 32);

        // backpressure
        axi.s_axi_rready  = 1'b0;
        axi.s_axi_arvalid = 1'b1;
        a   = 32'h0000_0100;
        acc = 0;
        axi.s_axi_araddr = a;
        repeat (8) begin
            @(negedge clk_IMP);
            if (axi.s_axi_arready) begin
                acc++;
                @(posedge clk_IMP);
                #1;
                a = a + 4;
                axi.s_axi_araddr = a;
            end else begin
                @(posedge clk_IMP);
                #1;
            end
        end
        chk("bp_accepted", 32'(acc), 3);
        @(negedge clk_IMP);
        chk("bp_arready", 32'(axi.s_axi_arready), 0);
        @(posedge clk_IMP);
        #1;
        axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready  = 1'b1;
        idle(5);
        @(negedge clk_IMP);
        chk("bp_arready_back", 32'(axi.s_axi_arready), 1);
        idle(1);

        // out of range, with an in-range read between
        pulse_clr();
        send_ar(32'h0000_1000);
        send_ar(32'h0000_0010);
        send_ar(32'hFFFF_FFFC);
        idle(5);
        chk("oor_err_cnt", 32'(stat_err_cnt), 2);
        chk("oor_rd_cnt", stat_rd_cnt, 3);

        // stat_clr coincident with an R handshake
        send_ar(32'h0000_0020);
        idle(1);
        stat_clr = 1'b1;
        @(negedge clk_IMP);
        chk("clr_hs_rvalid", 32'(axi.s_axi_rvalid), 1);
        @(posedge clk_IMP);
        #1;
        stat_clr = 1'b0;
        @(negedge clk_IMP);
        chk("clr_cnt0", stat_rd_cnt, 0);
        idle(1);
        send_ar(32'h0000_0024);
        idle(3);
        chk("clr_cnt1", stat_rd_cnt, 1);

        // randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    case ($urandom % 4)
                        0: a = 32'h0000_1000 + ($urandom & 32'h00FF_FFFC);
                        1: a = 32'hFFFF_FFF0 | ($urandom % 16);
                        default: a = BASE + 32'(($urandom % (1 << AW)) * 4)
                                          + ($urandom % 4);
                    endcase
                    send_ar(a);
                    idle($urandom % 3);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    axi.s_axi_rready = ($urandom % 3) != 0;
                    idle(1);
                end
            end
        join
        axi.s_axi_rready = 1'b1;
        idle(6);

        // reset with two queued beats and one read in flight
        axi.s_axi_rready = 1'b0;
        send_ar(32'h0000_0040);
        send_ar(32'h0000_0044);
        send_ar(32'h0000_0048);
        rst_IMP = 1'b1;
        idle(1);
        rst_IMP = 1'b0;
        @(negedge clk_IMP);
        chk("mid_rst_rvalid", 32'(axi.s_axi_rvalid), 0);
        chk("mid_rst_arready", 32'(axi.s_axi_arready), 1);
        axi.s_axi_rready = 1'b1;
        idle(5);
        @(negedge clk_IMP);
        chk("mid_rst_no_stale", 32'(axi.s_axi_rvalid), 0);
        chk("mid_rst_rd_cnt", stat_rd_cnt, 0);
        idle(1);

        send_ar(32'h0000_0010);
        idle(4);
        chk("post_rst_read", stat_rd_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
